// File: rtl/mem_block_mover_if.sv
// mem_block_mover_if: command, status and byte-memory bus signals of the block mover
//   master modport : the mover (takes command + ReadData, drives memory bus + status)
//   slave modport  : command source / memory side
interface mem_block_mover_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              Start;
  logic              Mode;
  logic [ADDR_W-1:0] SrcAddr;
  logic [ADDR_W-1:0] DstAddr;
  logic [ADDR_W:0]   Length;
  logic [DATA_W-1:0] FillData;
  logic [DATA_W-1:0] ReadData;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic              MemRead;
  logic              MemWrite;
  logic              Busy;
  logic              Done;
  logic [DATA_W-1:0] Checksum;
  modport master (
    input  Start, Mode, SrcAddr, DstAddr, Length, FillData, ReadData,
    output Address, WriteData, MemRead, MemWrite, Busy, Done, Checksum
  );
  modport slave (
    output Start, Mode, SrcAddr, DstAddr, Length, FillData, ReadData,
    input  Address, WriteData, MemRead, MemWrite, Busy, Done, Checksum
  );
endinterface

// File: rtl/mem_block_mover.sv
// mem_block_mover: copies or fills a block of bytes in a single-port byte memory
//   Clk   : clock, all state on posedge
//   Reset : synchronous active-high reset
//   bus   : command (Start/Mode/SrcAddr/DstAddr/Length/FillData), memory bus
//           (Address/WriteData/MemRead/MemWrite/ReadData), status (Busy/Done/Checksum)
module mem_block_mover #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic                Clk,
  input logic                Reset,
  mem_block_mover_if.master  bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
  state_t            st_q, st_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d, i_q, i_d, i_nx;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [ADDR_W-1:0] i_lo, nx_lo;
  assign i_nx  = i_q + (ADDR_W+1)'(1);
  assign i_lo  = i_q[ADDR_W-1:0];
  assign nx_lo = i_nx[ADDR_W-1:0];
  // Outputs are registered: each branch computes what the next state drives.
  // In copy mode wdata_q doubles as the read buffer, loaded from ReadData at the RD-ending edge.
  always_comb begin
    st_d    = st_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    i_d     = i_q;
    sum_d   = sum_q;
    addr_d  = '0;
    wdata_d = '0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (st_q)
      IDLE: if (bus.Start) begin
        src_d  = bus.SrcAddr;
        dst_d  = bus.DstAddr;
        len_d  = bus.Length;
        mode_d = bus.Mode;
        fill_d = bus.FillData;
        i_d    = '0;
        sum_d  = '0;
        if (bus.Length == '0) begin
          st_d   = FIN;
          done_d = 1'b1;
        end else if (!bus.Mode) begin
          st_d   = RD;
          addr_d = bus.SrcAddr;
          rd_d   = 1'b1;
          busy_d = 1'b1;
        end else begin
          st_d    = WR;
          addr_d  = bus.DstAddr;
          wdata_d = bus.FillData;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RD: begin
        st_d    = WR;
        addr_d  = dst_q + i_lo;
        wdata_d = bus.ReadData;
        wr_d    = 1'b1;
        busy_d  = 1'b1;
      end
      WR: begin
        sum_d = sum_q + wdata_q;
        i_d   = i_nx;
        if (i_nx == len_q) begin
          st_d   = FIN;
          done_d = 1'b1;
        end else if (!mode_q) begin
          st_d   = RD;
          addr_d = src_q + nx_lo;
          rd_d   = 1'b1;
          busy_d = 1'b1;
        end else begin
          st_d    = WR;
          addr_d  = dst_q + nx_lo;
          wdata_d = fill_q;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      FIN: st_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      st_q    <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      i_q     <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      i_q     <= i_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus.Address   = addr_q;
  assign bus.WriteData = wdata_q;
  assign bus.MemRead   = rd_q;
  assign bus.MemWrite  = wr_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Checksum  = sum_q;
endmodule

// File: tb/tb_mem_block_mover.sv
// tb_mem_block_mover: directed self-checking bench with a 256-byte memory model
module tb_mem_block_mover;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b0;
  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;
  int busy_n, done_n, done_at, rd_n, wr_n, both_n;
  mem_block_mover_if #(.ADDR_W(8), .DATA_W(8)) bif ();
  mem_block_mover #(.ADDR_W(8), .DATA_W(8)) dut (.Clk(clk), .Reset(rst), .bus(bif.master));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bif.MemWrite) begin
      mem[bif.Address] <= bif.WriteData;
    end
  end
  assign bif.ReadData = bif.MemRead ? mem[bif.Address] : 8'h00;
  task automatic do_preload();
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask
  // Issues one command at a negedge, then scrambles the command inputs and
  // observes ncyc cycles; optionally pulses Start again in cycle restart_at.
  task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [8:0] l, input logic [7:0] f, input int ncyc, input int restart_at);
    bif.Mode = m;
    bif.SrcAddr = s;
    bif.DstAddr = d;
    bif.Length = l;
    bif.FillData = f;
    bif.Start = 1'b1;
    @(negedge clk);
    bif.Start = 1'b0;
    bif.Mode = ~m;
    bif.SrcAddr = ~s;
    bif.DstAddr = ~d;
    bif.Length = 9'd1;
    bif.FillData = ~f;
    busy_n = 0; done_n = 0; done_at = 0; rd_n = 0; wr_n = 0; both_n = 0;
    for (int c = 1; c <= ncyc; c++) begin
      bif.Start = (c == restart_at);
      if (bif.Busy) busy_n++;
      if (bif.Done) begin
        done_n++;
        if (done_at == 0) done_at = c;
      end
      if (bif.MemRead) rd_n++;
      if (bif.MemWrite) wr_n++;
      if (bif.MemRead && bif.MemWrite) both_n++;
      @(negedge clk);
    end
    bif.Start = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bif.Address, bif.WriteData, bif.MemRead, bif.MemWrite, bif.Busy, bif.Done, bif.Checksum} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h wd=%h rd=%b wr=%b busy=%b done=%b cs=%h, want all 0",
               bif.Address, bif.WriteData, bif.MemRead, bif.MemWrite, bif.Busy, bif.Done, bif.Checksum);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_copy();
    do_preload();
    run_cmd(1'b0, 8'h10, 8'h80, 9'd4, 8'h00, 11, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[8'h80 + k] !== 8'(8'h10 + k)) begin
        errors++;
        $display("FAIL copy_data[%0d]: got %h want %h", k, mem[8'h80 + k], 8'(8'h10 + k));
      end
    end
    checks++;
    if (busy_n !== 8 || done_at !== 9 || done_n !== 1) begin
      errors++;
      $display("FAIL copy_timing: busy=%0d done_at=%0d done_n=%0d want 8 9 1", busy_n, done_at, done_n);
    end
    checks++;
    if (rd_n !== 4 || wr_n !== 4 || both_n !== 0) begin
      errors++;
      $display("FAIL copy_accesses: rd=%0d wr=%0d both=%0d want 4 4 0", rd_n, wr_n, both_n);
    end
    checks++;
    if (bif.Checksum !== 8'h46) begin
      errors++;
      $display("FAIL copy_checksum: got %h want 46", bif.Checksum);
    end
  endtask
  task automatic test_fill();
    do_preload();
    run_cmd(1'b1, 8'h00, 8'h20, 9'd3, 8'hA5, 6, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[8'h20 + k] !== ((k < 3) ? 8'hA5 : 8'h23)) begin
        errors++;
        $display("FAIL fill_data[%0d]: got %h want %h", k, mem[8'h20 + k], (k < 3) ? 8'hA5 : 8'h23);
      end
    end
    checks++;
    if (rd_n !== 0 || wr_n !== 3 || busy_n !== 3 || done_at !== 4) begin
      errors++;
      $display("FAIL fill_timing: rd=%0d wr=%0d busy=%0d done_at=%0d want 0 3 3 4", rd_n, wr_n, busy_n, done_at);
    end
    checks++;
    if (bif.Checksum !== 8'hEF) begin
      errors++;
      $display("FAIL fill_checksum: got %h want ef", bif.Checksum);
    end
  endtask
  task automatic test_wrap();
    logic [7:0] exp [3];
    exp[0] = 8'hFE; exp[1] = 8'hFF; exp[2] = 8'h00;
    do_preload();
    run_cmd(1'b0, 8'hFE, 8'h01, 9'd3, 8'h00, 9, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mem[k + 1] !== exp[k]) begin
        errors++;
        $display("FAIL wrap_data[%0d]: got %h want %h", k + 1, mem[k + 1], exp[k]);
      end
    end
    checks++;
    if (bif.Checksum !== 8'hFD || done_at !== 7) begin
      errors++;
      $display("FAIL wrap_checksum: cs=%h done_at=%0d want fd 7", bif.Checksum, done_at);
    end
  endtask
  task automatic test_zero_length();
    run_cmd(1'b0, 8'h00, 8'h00, 9'd0, 8'h00, 3, 0);
    checks++;
    if (done_at !== 1 || done_n !== 1 || rd_n !== 0 || wr_n !== 0 || busy_n !== 0) begin
      errors++;
      $display("FAIL zero_len: done_at=%0d done_n=%0d rd=%0d wr=%0d busy=%0d want 1 1 0 0 0",
               done_at, done_n, rd_n, wr_n, busy_n);
    end
    checks++;
    if (bif.Checksum !== 8'h00) begin
      errors++;
      $display("FAIL zero_checksum: got %h want 00", bif.Checksum);
    end
  endtask
  task automatic test_restart_ignored();
    int bad = 0;
    do_preload();
    run_cmd(1'b0, 8'h40, 8'h90, 9'd8, 8'h00, 20, 3);
    for (int k = 0; k < 8; k++) if (mem[8'h90 + k] !== 8'(8'h40 + k)) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL restart_data: %0d wrong bytes, want 0", bad);
    end
    checks++;
    if (wr_n !== 8 || done_n !== 1 || done_at !== 17) begin
      errors++;
      $display("FAIL restart_ignored: wr=%0d done_n=%0d done_at=%0d want 8 1 17", wr_n, done_n, done_at);
    end
    checks++;
    if (bif.Checksum !== 8'h1C) begin
      errors++;
      $display("FAIL restart_checksum: got %h want 1c", bif.Checksum);
    end
  endtask
  task automatic test_full_length();
    int bad = 0;
    do_preload();
    run_cmd(1'b1, 8'h00, 8'h37, 9'h100, 8'h5A, 260, 0);
    for (int k = 0; k < 256; k++) if (mem[k] !== 8'h5A) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL full_data: %0d wrong bytes, want 0", bad);
    end
    checks++;
    if (wr_n !== 256 || busy_n !== 256 || done_at !== 257 || done_n !== 1) begin
      errors++;
      $display("FAIL full_timing: wr=%0d busy=%0d done_at=%0d done_n=%0d want 256 256 257 1",
               wr_n, busy_n, done_at, done_n);
    end
  endtask
  task automatic test_reset_midway();
    int w = 0;
    do_preload();
    bif.Mode = 1'b1;
    bif.DstAddr = 8'h50;
    bif.Length = 9'd6;
    bif.FillData = 8'h3C;
    bif.Start = 1'b1;
    @(negedge clk);
    bif.Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bif.MemWrite !== 1'b1 || bif.Address !== 8'h52) begin
      errors++;
      $display("FAIL midreset_third_wr: wr=%b addr=%h want 1 52", bif.MemWrite, bif.Address);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bif.Address, bif.WriteData, bif.MemRead, bif.MemWrite, bif.Busy, bif.Done, bif.Checksum} !== 28'h0) begin
      errors++;
      $display("FAIL midreset_outputs: addr=%h wd=%h rd=%b wr=%b busy=%b done=%b cs=%h want all 0",
               bif.Address, bif.WriteData, bif.MemRead, bif.MemWrite, bif.Busy, bif.Done, bif.Checksum);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (bif.MemWrite) w++;
      @(negedge clk);
    end
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL midreset_writes: %0d writes after reset, want 0", w);
    end
    checks++;
    if (mem[8'h50] !== 8'h3C || mem[8'h51] !== 8'h3C || mem[8'h53] !== 8'h53 || mem[8'h55] !== 8'h55) begin
      errors++;
      $display("FAIL midreset_mem: got %h %h %h %h want 3c 3c 53 55", mem[8'h50], mem[8'h51], mem[8'h53], mem[8'h55]);
    end
    run_cmd(1'b1, 8'h00, 8'hC0, 9'd2, 8'h07, 5, 0);
    checks++;
    if (mem[8'hC0] !== 8'h07 || mem[8'hC1] !== 8'h07 || done_at !== 3 || bif.Checksum !== 8'h0E) begin
      errors++;
      $display("FAIL midreset_restart: mem=%h %h done_at=%0d cs=%h want 07 07 3 0e",
               mem[8'hC0], mem[8'hC1], done_at, bif.Checksum);
    end
  endtask
  task automatic test_back_to_back();
    do_preload();
    run_cmd(1'b1, 8'h00, 8'h60, 9'd2, 8'h11, 3, 0);
    checks++;
    if (done_at !== 3 || bif.Checksum !== 8'h22) begin
      errors++;
      $display("FAIL b2b_first: done_at=%0d cs=%h want 3 22", done_at, bif.Checksum);
    end
    run_cmd(1'b0, 8'h61, 8'h70, 9'd1, 8'h00, 3, 0);
    checks++;
    if (mem[8'h70] !== 8'h11 || done_at !== 3 || bif.Checksum !== 8'h11 || rd_n !== 1) begin
      errors++;
      $display("FAIL b2b_second: mem=%h done_at=%0d cs=%h rd=%0d want 11 3 11 1",
               mem[8'h70], done_at, bif.Checksum, rd_n);
    end
  endtask
  initial begin
    bif.Start = 1'b0;
    bif.Mode = 1'b0;
    bif.SrcAddr = '0;
    bif.DstAddr = '0;
    bif.Length = '0;
    bif.FillData = '0;
    test_reset();
    test_copy();
    test_fill();
    test_wrap();
    test_zero_length();
    test_restart_ignored();
    test_full_length();
    test_reset_midway();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Initiator (master) for the single-port byte data-memory interface: Address, WriteData, MemWrite, MemRead, ReadData.
- On a Start command it copies a block of bytes from a source region to a destination region, or fills a region with a constant.
- It drives the memory control/address/data lines itself, so a memory-init or data-staging step needs no CPU involvement.
- Sits beside the data memory; a mux (outside this block) selects between this block and the datapath while Busy is high.

Parameters:
- ADDR_W, 8, memory address width; the memory has 2^ADDR_W bytes.
- DATA_W, 8, memory data width.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  command strobe; sampled only in IDLE.
- Mode  in  1  0 = copy, 1 = fill.
- SrcAddr  in  ADDR_W  copy source base address; ignored in fill mode.
- DstAddr  in  ADDR_W  destination base address.
- Length  in  ADDR_W+1  byte count, 0..2^ADDR_W.
- FillData  in  DATA_W  fill value.
- ReadData  in  DATA_W  memory read data; the memory returns it combinationally while MemRead=1.
- Address  out  ADDR_W  memory address (registered).
- WriteData  out  DATA_W  memory write data (registered).
- MemRead  out  1  memory read enable (registered).
- MemWrite  out  1  memory write enable (registered); memory writes on the posedge ending the cycle.
- Busy  out  1  high while a transfer is in progress.
- Done  out  1  one-cycle completion pulse.
- Checksum  out  DATA_W  mod-2^DATA_W sum of all bytes written by the last command; holds until the next accepted Start.

Behaviour:
- Reset (synchronous): next state IDLE. Address, WriteData, MemRead, MemWrite, Busy, Done and Checksum all 0.
- Reset mid-transfer abandons the transfer immediately. No MemWrite is asserted in the cycle after the reset edge. Bytes already written stay written.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - All outputs 0 except Checksum, which holds.
  - On Start=1: latch Src, Dst, Length, Mode and FillData; clear Checksum; clear the byte index i.
  - If Length=0, go to FIN.
  - Else go to RD (copy) or WR (fill).
- RD:
  - Drive Address=Src+i, MemRead=1, MemWrite=0, Busy=1.
  - At the ending edge, capture ReadData into an internal byte buffer and go to WR.
- WR:
  - Drive Address=Dst+i, WriteData=buffer (copy) or FillData (fill), MemWrite=1, MemRead=0, Busy=1.
  - At the ending edge: Checksum += WriteData; i += 1.
  - If i+1 == Length, go to FIN; else go to RD (copy) or WR (fill).
- FIN:
  - Done=1, Busy=0, MemRead=MemWrite=0.
  - Next state IDLE.
- MemRead and MemWrite are never high in the same cycle.
- Address arithmetic is modulo 2^ADDR_W: Src+i and Dst+i wrap from 255 to 0.
- Length=256 (ADDR_W=8) is legal. Every byte is touched once; i is ADDR_W+1 bits.
- Latency from the Start edge:
  - Copy of N bytes: Busy high for 2N cycles; Done in cycle 2N+1.
  - Fill of N bytes: Busy for N cycles; Done in cycle N+1.
  - Length=0: Done in cycle 1, no memory access.
- Start while not in IDLE (RD/WR/FIN) is ignored; it is not queued.
- Overlapping copy regions: bytes are processed strictly ascending, read i then write i. Results for Dst > Src overlap follow that order; no overlap correction is done.
- Command inputs may change after the accepting edge without effect.

Test Plan:
- Memory preloaded with mem[i]=i. Copy Src=0x10, Dst=0x80, Length=4 -> four RD/WR pairs; mem[0x80..0x83]=10,11,12,13; Busy for 8 cycles; Done in cycle 9; Checksum=0x46.
- Fill Dst=0x20, Length=3, FillData=0xA5 -> mem[0x20..0x22]=A5; MemRead never high; Done in cycle 4; Checksum=0xEF.
- Wrap: copy Src=0xFE, Dst=0x01, Length=3 -> reads 0xFE, 0xFF, 0x00; mem[1..3]=FE,FF,00 (values sampled before any overwrite); Checksum=0xFD.
- Length=0 -> no MemRead/MemWrite; Done pulses in cycle 1; Checksum=0.
- Start pulsed again during a copy (Length=8) -> ignored; exactly 8 writes; a single Done pulse.
- Reset asserted in the cycle where the third WR of a fill (Length=6, 0x3C) is driven -> mem[Dst..Dst+1]=3C written, with no further writes after the reset edge. All outputs are 0 next cycle; a new Start is then accepted normally.
